// File: rtl/lock_entry_ctrl.sv
// Entry sequencer for the 5-digit password comparator. It steps the digit
// position, collects match results, issues grant/deny, and enforces lockout.
module lock_entry_ctrl #(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCK_CYCLES    = 200,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       clear,
    input  logic       cmp_match,
    output logic [3:0] cmp_digit,
    output logic [2:0] cmp_pos,
    output logic       unlock,
    output logic       deny,
    output logic       alarm,
    output logic       busy,
    output logic [1:0] fail_count
);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int IW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] FAIL_MAX = 2'(MAX_FAILS);

    typedef enum logic [1:0] {ENTRY, GRANT, DENY, LOCKOUT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    pos_nxt;
    logic          ok, ok_nxt;
    logic [1:0]    fail_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic [TW-1:0] tmr, tmr_nxt;

    assign cmp_digit = digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENTRY;
            cmp_pos    <= 3'd1;
            ok         <= 1'b1;
            fail_count <= '0;
            idle_cnt   <= '0;
            tmr        <= '0;
            unlock     <= 1'b0;
            deny       <= 1'b0;
            alarm      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmp_pos    <= pos_nxt;
            ok         <= ok_nxt;
            fail_count <= fail_nxt;
            idle_cnt   <= idle_nxt;
            tmr        <= tmr_nxt;
            // Outputs follow the next state so each verdict shows one cycle after its strobe
            unlock     <= (state_nxt == GRANT);
            deny       <= (state_nxt == DENY);
            alarm      <= (state_nxt == LOCKOUT);
            busy       <= (state_nxt != ENTRY);
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = cmp_pos;
        ok_nxt    = ok;
        fail_nxt  = fail_count;
        idle_nxt  = idle_cnt;
        tmr_nxt   = tmr;
        case (state)
            ENTRY: begin
                if (clear) begin
                    pos_nxt  = 3'd1;
                    ok_nxt   = 1'b1;
                    idle_nxt = '0;
                end else if (digit_valid) begin
                    idle_nxt = '0;
                    if (cmp_pos == 3'd5) begin
                        pos_nxt = 3'd1;
                        ok_nxt  = 1'b1;
                        tmr_nxt = '0;
                        if (ok && cmp_match) begin
                            state_nxt = GRANT;
                            fail_nxt  = '0;
                        end else begin
                            state_nxt = DENY;
                            if (fail_count != FAIL_MAX)
                                fail_nxt = fail_count + 2'd1;
                        end
                    end else begin
                        pos_nxt = cmp_pos + 3'd1;
                        ok_nxt  = ok & cmp_match;
                    end
                end else if (cmp_pos != 3'd1) begin
                    // Timeout aborts exactly like clear and is not a failure
                    if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                        pos_nxt  = 3'd1;
                        ok_nxt   = 1'b1;
                        idle_nxt = '0;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            GRANT: begin
                if (tmr == TW'(UNLOCK_CYCLES - 1)) begin
                    state_nxt = ENTRY;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            DENY: begin
                tmr_nxt   = '0;
                state_nxt = (fail_count == FAIL_MAX) ? LOCKOUT : ENTRY;
            end
            LOCKOUT: begin
                if (tmr == TW'(LOCK_CYCLES - 1)) begin
                    state_nxt = ENTRY;
                    tmr_nxt   = '0;
                    fail_nxt  = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: state_nxt = ENTRY;
        endcase
    end
endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed self-checking bench for lock_entry_ctrl; a tiny comparator model
// supplies cmp_match for the stored password 5-1-7-3-9.
module tb_lock_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = '0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       cmp_match;
    logic [3:0] cmp_digit;
    logic [2:0] cmp_pos;
    logic       unlock, deny, alarm, busy;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    lock_entry_ctrl #(
        .MAX_FAILS(3), .UNLOCK_CYCLES(50), .LOCK_CYCLES(200), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid),
        .clear(clear), .cmp_match(cmp_match), .cmp_digit(cmp_digit),
        .cmp_pos(cmp_pos), .unlock(unlock), .deny(deny), .alarm(alarm),
        .busy(busy), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (cmp_pos)
            3'd1: cmp_match = (cmp_digit == 4'd5);
            3'd2: cmp_match = (cmp_digit == 4'd1);
            3'd3: cmp_match = (cmp_digit == 4'd7);
            3'd4: cmp_match = (cmp_digit == 4'd3);
            3'd5: cmp_match = (cmp_digit == 4'd9);
            default: cmp_match = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        digit = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({cmp_pos, unlock, deny, alarm, busy, fail_count} !== {3'd1, 4'b0000, 2'd0}) begin
            errors++;
            $display("FAIL reset: got pos=%0d u=%b d=%b a=%b b=%b f=%0d, want pos=1 all 0",
                     cmp_pos, unlock, deny, alarm, busy, fail_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_grant();
        logic [3:0] seq [5] = '{4'd5, 4'd1, 4'd7, 4'd3, 4'd9};
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmp_pos !== 3'(i + 1)) begin
                errors++;
                $display("FAIL grant_pos: step %0d got %0d want %0d", i, cmp_pos, i + 1);
            end
            digit = seq[i];
            checks++;
            if (cmp_digit !== seq[i]) begin
                errors++;
                $display("FAIL cmp_digit: got %0d want %0d", cmp_digit, seq[i]);
            end
            send(seq[i]);
        end
        checks++;
        if ({unlock, deny, busy, fail_count, cmp_pos} !== {3'b101, 2'd0, 3'd1}) begin
            errors++;
            $display("FAIL grant_verdict: got u=%b d=%b b=%b f=%0d pos=%0d, want u=1 d=0 b=1 f=0 pos=1",
                     unlock, deny, busy, fail_count, cmp_pos);
        end
        for (int i = 0; i < 49; i++) begin
            tick();
            if (unlock !== 1'b1 || deny !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL grant_hold: %0d cycles with unlock!=1 or deny!=0, want 0", bad);
        end
        tick();
        checks++;
        if ({unlock, busy} !== 2'b00) begin
            errors++;
            $display("FAIL grant_end: got u=%b b=%b want 0 0", unlock, busy);
        end
    endtask

    task automatic test_deny(input logic [3:0] d0, input logic [3:0] d4,
                             input logic [1:0] exp_fail, input logic last_before_lock);
        send(d0); send(4'd1); send(4'd7); send(4'd3); send(d4);
        checks++;
        if ({deny, unlock, busy, fail_count} !== {3'b101, exp_fail}) begin
            errors++;
            $display("FAIL deny_pulse: got d=%b u=%b b=%b f=%0d want d=1 u=0 b=1 f=%0d",
                     deny, unlock, busy, fail_count, exp_fail);
        end
        tick();
        checks++;
        if ({deny, alarm, busy, cmp_pos} !== {1'b0, last_before_lock, last_before_lock, 3'd1}) begin
            errors++;
            $display("FAIL deny_after: got d=%b a=%b b=%b pos=%0d want d=0 a=%b b=%b pos=1",
                     deny, alarm, busy, cmp_pos, last_before_lock, last_before_lock);
        end
    endtask

    task automatic test_lockout();
        int bad = 0;
        test_deny(4'd5, 4'd8, 2'd1, 1'b0);
        test_deny(4'd4, 4'd9, 2'd2, 1'b0);
        test_deny(4'd5, 4'd0, 2'd3, 1'b1);
        digit = 4'd5;
        for (int i = 0; i < 199; i++) begin
            digit_valid = (i < 60);
            clear = (i == 30);
            tick();
            if (alarm !== 1'b1 || busy !== 1'b1 || cmp_pos !== 3'd1) bad++;
        end
        digit_valid = 1'b0;
        clear = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lockout_hold: %0d bad cycles, want 0", bad);
        end
        tick();
        checks++;
        if ({alarm, busy, fail_count, cmp_pos} !== {2'b00, 2'd0, 3'd1}) begin
            errors++;
            $display("FAIL lockout_end: got a=%b b=%b f=%0d pos=%0d want 0 0 0 1",
                     alarm, busy, fail_count, cmp_pos);
        end
    endtask

    task automatic test_clear();
        send(4'd5); send(4'd1);
        digit = 4'd7;
        digit_valid = 1'b1;
        clear = 1'b1;
        tick();
        digit_valid = 1'b0;
        clear = 1'b0;
        checks++;
        if ({cmp_pos, deny, busy} !== {3'd1, 2'b00}) begin
            errors++;
            $display("FAIL clear: got pos=%0d d=%b b=%b want pos=1 d=0 b=0", cmp_pos, deny, busy);
        end
        test_grant();
    endtask

    task automatic test_timeout();
        test_deny(4'd5, 4'd8, 2'd1, 1'b0);
        send(4'd5); send(4'd1);
        repeat (99) tick();
        checks++;
        if (cmp_pos !== 3'd3) begin
            errors++;
            $display("FAIL timeout_early: got pos=%0d want 3", cmp_pos);
        end
        tick();
        checks++;
        if ({cmp_pos, fail_count, deny, busy} !== {3'd1, 2'd1, 2'b00}) begin
            errors++;
            $display("FAIL timeout_abort: got pos=%0d f=%0d d=%b b=%b want 1 1 0 0",
                     cmp_pos, fail_count, deny, busy);
        end
        repeat (150) tick();
        checks++;
        if ({cmp_pos, fail_count, deny, busy, unlock, alarm} !== {3'd1, 2'd1, 4'b0000}) begin
            errors++;
            $display("FAIL idle_pos1: got pos=%0d f=%0d d=%b b=%b u=%b a=%b want 1 1 0 0 0 0",
                     cmp_pos, fail_count, deny, busy, unlock, alarm);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        test_deny(4'd5, 4'd8, 2'd1, 1'b0);
        test_deny(4'd5, 4'd8, 2'd2, 1'b0);
        send(4'd5); send(4'd1); send(4'd7); send(4'd3); send(4'd9);
        checks++;
        if ({unlock, fail_count} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL recover_grant: got u=%b f=%0d want u=1 f=0", unlock, fail_count);
        end
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmp_pos, unlock, deny, alarm, busy, fail_count} !== {3'd1, 4'b0000, 2'd0}) begin
            errors++;
            $display("FAIL async_reset: got pos=%0d u=%b d=%b a=%b b=%b f=%0d want pos=1 all 0",
                     cmp_pos, unlock, deny, alarm, busy, fail_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cmp_pos, unlock, busy} !== {3'd1, 2'b00}) begin
            errors++;
            $display("FAIL post_reset: got pos=%0d u=%b b=%b want 1 0 0", cmp_pos, unlock, busy);
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_deny(4'd5, 4'd8, 2'd1, 1'b0);
        test_deny(4'd4, 4'd9, 2'd2, 1'b0);
        test_reset();
        test_lockout();
        test_clear();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
